inv_key_schedule: RTL

- Iterative AES-128 inverse key-schedule engine for the decryption datapath.
- Loads the final (round-10) round key and emits round keys 10, 9, …, 0, one per accepted handshake.
- Each round key is derived in place from the next-higher one.
- Sits between key storage and the inverse-cipher round logic, in the opposite direction to the forward round-key generator.

---
 rtl/aes_key_pkg.sv | 65 ++++++
 rtl/aes_sbox.sv | 28 ++
 rtl/inv_key_step.sv | 37 +++
 rtl/inv_key_schedule.sv | 112 +++++++++++
 4 files changed

// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule definitions: round index, Rcon, FSM states and word slices.
// INV_KEY_EQ_INV_CIPHER_EN adds the InvMixColumns column function for the equivalent inverse cipher.
package aes_key_pkg;

  localparam int NR_AES128 = 10;
  localparam int WORD_W    = 32;
  localparam int W0_LSB    = 96;
  localparam int W1_LSB    = 64;
  localparam int W2_LSB    = 32;
  localparam int W3_LSB    = 0;

  typedef logic [3:0] round_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Rcon for the forward step that produced round r; zero outside 1..10.
  function automatic logic [31:0] rcon_word(input round_t r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

`ifdef INV_KEY_EQ_INV_CIPHER_EN
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte index 3 is row 0 (bits [31:24]) of the column.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    a = c;
    for (int i = 0; i < 4; i++) begin
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[3] ^ mb[2] ^ md[1] ^ m9[0],
            m9[3] ^ me[2] ^ mb[1] ^ md[0],
            md[3] ^ m9[2] ^ me[1] ^ mb[0],
            mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = SBOX[{din, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_step.sv
// One inverse AES-128 key-schedule step: round-r key in, round r-1 key out, combinational.
module inv_key_step
  import aes_key_pkg::*;
(
  input  logic [127:0] key_in,
  input  round_t       round,
  output logic [127:0] key_prev
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] v0, v1, v2, v3;
  logic [WORD_W-1:0] rot, sub;

  assign w0 = key_in[W0_LSB +: WORD_W];
  assign w1 = key_in[W1_LSB +: WORD_W];
  assign w2 = key_in[W2_LSB +: WORD_W];
  assign w3 = key_in[W3_LSB +: WORD_W];

  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;

  // v3 is the recovered old w3, which fed SubWord(RotWord()) in the forward step.
  assign rot = {v3[23:0], v3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[i*8 +: 8]),
      .dout (sub[i*8 +: 8])
    );
  end

  assign v0 = w0 ^ sub ^ rcon_word(round);

  assign key_prev = {v0, v1, v2, v3};

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: emits round keys NR..0, first key 1 cycle after start, one per key_valid&key_ready.
// Stalls hold key_out/key_round; INV_KEY_EQ_INV_CIPHER_EN emits InvMixColumns'd keys for rounds NR-1..1.
module inv_key_schedule
  import aes_key_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [127:0] raw_q, raw_d;
  round_t       round_q, round_d;
  logic         vld_q, vld_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] prev_key;
  logic         hs;

  inv_key_step u_step (
    .key_in   (raw_q),
    .round    (round_q),
    .key_prev (prev_key)
  );

  assign hs = vld_q & key_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      raw_q   <= '0;
      round_q <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      round_q <= round_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    round_d = round_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          raw_d   = last_key;
          round_d = round_t'(NR);
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (hs) begin
          if (round_q != '0) begin
            raw_d   = prev_key;
            round_d = round_q - 4'd1;
          end else begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef INV_KEY_EQ_INV_CIPHER_EN
  logic mix_sel;
  assign mix_sel = (round_q != '0) && (round_q != round_t'(NR));
  assign key_out = mix_sel ? {inv_mix_col(raw_q[W0_LSB +: WORD_W]),
                              inv_mix_col(raw_q[W1_LSB +: WORD_W]),
                              inv_mix_col(raw_q[W2_LSB +: WORD_W]),
                              inv_mix_col(raw_q[W3_LSB +: WORD_W])} : raw_q;
`else
  assign key_out = raw_q;
`endif

  assign key_round = round_q;
  assign key_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
